// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: sequences the PC into a combinational TLB/ROM, pairs MVI with its
// immediate word and hands the pair to the core over valid/ready. FETCH_ILLEGAL_EN adds illegal-opcode trapping.
module fetch_unit #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned NUM_INSTR = 38,
  parameter int unsigned START_PC  = 0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              run,
  output logic [ADDR_W-1:0] addr,
  input  logic [15:0]       tlb_data,
  output logic [15:0]       instr_out,
  output logic [15:0]       imm_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              done
`ifdef FETCH_ILLEGAL_EN
  ,
  output logic              illegal
`endif
);

  localparam int unsigned WORD_W = 16;
  localparam logic [3:0]  OPC_MVI = 4'b0100;
  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_PC);
  localparam logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(NUM_INSTR);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_FETCH_IMM, S_HOLD, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] imm_q, imm_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef FETCH_ILLEGAL_EN
  logic              illegal_q, illegal_d;
`endif

  logic is_mvi_c;
  logic is_ill_c;
  logic at_end_c;

  assign is_mvi_c = (tlb_data[15:12] == OPC_MVI);
  assign at_end_c = (pc_q == END_ADDR);

`ifdef FETCH_ILLEGAL_EN
  localparam logic [3:0] OPC_ILL_MIN = 4'b1011;
  assign is_ill_c = (tlb_data[15:12] >= OPC_ILL_MIN);
`else
  assign is_ill_c = 1'b0;
`endif

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; redirect outranks every other transition while busy
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (redirect)      state_d = S_FETCH;
        else if (is_ill_c) state_d = S_DONE;
        else if (is_mvi_c) state_d = S_FETCH_IMM;
        else               state_d = S_HOLD;
      end
      S_FETCH_IMM: state_d = redirect ? S_FETCH : S_HOLD;
      S_HOLD: begin
        if (redirect)         state_d = S_FETCH;
        else if (instr_ready) state_d = at_end_c ? S_DONE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values for PC and the presented instruction pair
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    imm_d   = imm_q;
    valid_d = valid_q;
`ifdef FETCH_ILLEGAL_EN
    illegal_d = illegal_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        valid_d = 1'b0;
        if (run) begin
          pc_d = START_ADDR;
`ifdef FETCH_ILLEGAL_EN
          illegal_d = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (is_ill_c) begin
`ifdef FETCH_ILLEGAL_EN
          illegal_d = 1'b1;
`endif
        end else begin
          instr_d = tlb_data;
          pc_d    = pc_q + ADDR_W'(1);
          if (!is_mvi_c) begin
            imm_d   = '0;
            valid_d = 1'b1;
          end
        end
      end
      S_FETCH_IMM: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else begin
          valid_d = 1'b1;
          // MVI as the final program word has no immediate to read
          if (at_end_c) begin
            imm_d = '0;
          end else begin
            imm_d = tlb_data;
            pc_d  = pc_q + ADDR_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (instr_ready) begin
          valid_d = 1'b0;
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  // Status flags follow the state being entered so they line up with it
  always_comb begin
    busy_d = (state_d == S_FETCH) || (state_d == S_FETCH_IMM) || (state_d == S_HOLD);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pc_q    <= START_ADDR;
      instr_q <= '0;
      imm_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FETCH_ILLEGAL_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FETCH_ILLEGAL_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign addr        = pc_q;
  assign instr_out   = instr_q;
  assign imm_out     = imm_q;
  assign instr_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef FETCH_ILLEGAL_EN
  assign illegal     = illegal_q;
`endif

endmodule
